// File: rtl/servo_cmd_shaper.sv
// -----------------------------------------------------------------------------
// servo_cmd_shaper
//
// Turns the four raw slide switches into a clean, rate-limited duty command
// for the downstream servo PWM generator.
//
//   sw  --> 2-flop synchroniser --> debounce --> clamp --> target
//   target --> ramp FSM (IDLE / WAIT / STEP) --> duty (one LSB per interval)
//
// The servo never sees a jump: duty moves by exactly one LSB every
// RAMP_CYCLES+1 clocks toward the current target, and the direction is
// re-evaluated on every step, so it follows a target that moves mid-ramp
// without ever overshooting it.
//
// Ports
//   clk        in   1        system clock
//   rst        in   1        synchronous, active-high reset
//   sw         in   DUTY_W   raw asynchronous switch inputs
//   duty       out  DUTY_W   registered duty command to the PWM stage
//   duty_upd   out  1        1-cycle pulse aligned with each duty change
//   busy       out  1        1 while duty != target (ramp in progress)
//   dbg_state  out  2        ramp FSM state (0=IDLE, 1=WAIT, 2=STEP)
//   dbg_target out  DUTY_W   accepted, clamped target value
//
// Handshake: there is no valid/ready pair here. duty is a level that is
// always valid; duty_upd is a single-cycle strobe, high on exactly the cycles
// where duty holds a value different from the previous cycle. The consumer
// never back-pressures this block.
//
// DUTY_INIT must lie inside [DUTY_MIN, DUTY_MAX]; it is the only value duty
// can hold that did not pass through the clamp.
// -----------------------------------------------------------------------------
module servo_cmd_shaper #(
    parameter int DUTY_W      = 4,
    parameter int DEB_CYCLES  = 500000,
    parameter int RAMP_CYCLES = 5000000,
    parameter int DUTY_MIN    = 2,
    parameter int DUTY_MAX    = 12,
    parameter int DUTY_INIT   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] sw,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              busy,
    output logic [1:0]        dbg_state,
    output logic [DUTY_W-1:0] dbg_target
);

    // Counter widths: the debounce counter must be able to hold DEB_CYCLES
    // itself (it saturates there); the ramp counter only reaches
    // RAMP_CYCLES-1, but +1 keeps the width non-zero when RAMP_CYCLES is 1.
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

    localparam logic [DUTY_W-1:0] DUTY_MIN_V  = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] DUTY_MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_INIT_V = DUTY_W'(DUTY_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    // Unsigned clamp into the safe servo range.
    function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] x);
        logic [DUTY_W-1:0] r;
        if (x < DUTY_MIN_V) begin
            r = DUTY_MIN_V;
        end else if (x > DUTY_MAX_V) begin
            r = DUTY_MAX_V;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [DUTY_W-1:0] sw_meta_q;
    logic [DUTY_W-1:0] sw_s_q;
    logic [DUTY_W-1:0] cand_q,    cand_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [DUTY_W-1:0] target_q,  target_d;

    state_t            state_q,    state_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [DUTY_W-1:0] duty_q,     duty_d;
    logic              duty_upd_q, duty_upd_d;
    logic              busy_q,     busy_d;

    // ------------------------------------------------------------------
    // Debounce: a synchronised value becomes the target only after it has
    // been seen unchanged for DEB_CYCLES consecutive edges. The counter then
    // parks at DEB_CYCLES so the same value is not reloaded every cycle.
    // The first acceptance after reset happens even when the value equals
    // DUTY_INIT, because the synchroniser and candidate start at zero.
    // ------------------------------------------------------------------
    always_comb begin
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        target_d  = target_q;
        if (sw_s_q != cand_q) begin
            cand_d    = sw_s_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q < DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
            if (deb_cnt_q == DEB_LAST) begin
                target_d = clamp(cand_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Ramp FSM next-state. All decisions look at the registered target and
    // duty; a target loaded on the same edge is seen one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ramp_cnt_d = ramp_cnt_q;
        duty_d     = duty_q;
        duty_upd_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (target_q != duty_q) begin
                    state_d    = S_WAIT;
                    ramp_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (target_q == duty_q) begin
                    // Target moved back onto duty while waiting: abandon.
                    state_d = S_IDLE;
                end else if (ramp_cnt_q == RAMP_LAST) begin
                    state_d = S_STEP;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                end
            end
            S_STEP: begin
                // Direction is taken from the target as it stands now. If the
                // target landed exactly on duty in the meantime, no step is
                // taken, which is what prevents overshoot. Because duty only
                // moves toward an in-range target, +1/-1 can never wrap.
                if (target_q > duty_q) begin
                    duty_d     = duty_q + DUTY_W'(1);
                    duty_upd_d = 1'b1;
                end else if (target_q < duty_q) begin
                    duty_d     = duty_q - DUTY_W'(1);
                    duty_upd_d = 1'b1;
                end
                state_d    = S_WAIT;
                ramp_cnt_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                ramp_cnt_d = '0;
            end
        endcase
    end

    // busy is registered from next-state values so it is coherent with the
    // duty and target that become visible on the same edge.
    always_comb begin
        busy_d = (duty_d != target_d);
    end

    // ------------------------------------------------------------------
    // Single sequential block: reset wins over every other update,
    // including a step that would otherwise happen on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            cand_q     <= '0;
            deb_cnt_q  <= '0;
            target_q   <= DUTY_INIT_V;
            state_q    <= S_IDLE;
            ramp_cnt_q <= '0;
            duty_q     <= DUTY_INIT_V;
            duty_upd_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Plain two-flop synchroniser, nothing between the stages.
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            cand_q     <= cand_d;
            deb_cnt_q  <= deb_cnt_d;
            target_q   <= target_d;
            state_q    <= state_d;
            ramp_cnt_q <= ramp_cnt_d;
            duty_q     <= duty_d;
            duty_upd_q <= duty_upd_d;
            busy_q     <= busy_d;
        end
    end

    assign duty       = duty_q;
    assign duty_upd   = duty_upd_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;
    assign dbg_target = target_q;

endmodule

// File: tb/tb_servo_cmd_shaper.sv
module tb_servo_cmd_shaper;

  localparam int DUTY_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DUTY_W-1:0] sw = 4'd7;
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;
  logic              busy;
  logic [1:0]        dbg_state;
  logic [DUTY_W-1:0] dbg_target;

  servo_cmd_shaper #(
    .DUTY_W(4), .DEB_CYCLES(4), .RAMP_CYCLES(3),
    .DUTY_MIN(2), .DUTY_MAX(12), .DUTY_INIT(7)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .duty(duty), .duty_upd(duty_upd), .busy(busy),
    .dbg_state(dbg_state), .dbg_target(dbg_target)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int upd_cnt       = 0;
  int range_bad     = 0;

  // event monitor: counts duty_upd pulses and out-of-range duty values
  always @(negedge clk) begin
    if (!rst) begin
      if (duty_upd === 1'b1) upd_cnt++;
      if (duty < 4'd2 || duty > 4'd12) range_bad++;
    end
  end

  // advance n posedges, then sample 1 time unit later
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw  = 4'd7;
    tick(3);
    rst = 1'b0;
    tick(12);
    upd_cnt = 0;
  endtask

  task automatic wait_duty(input logic [DUTY_W-1:0] v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (duty === v) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    sw  = 4'd7;
    tick(3);
    checks_total++;
    if (duty !== 4'd7 || busy !== 1'b0 || duty_upd !== 1'b0 || dbg_state !== 2'd0 || dbg_target !== 4'd7)
      $display("FAIL reset_state: duty=%0d busy=%0b upd=%0b st=%0d tgt=%0d, want 7/0/0/0/7",
               duty, busy, duty_upd, dbg_state, dbg_target);
    else checks_passed++;
    rst = 1'b0;
    upd_cnt = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (duty !== 4'd7 || busy !== 1'b0) bad++;
    end
    checks_total++;
    if (bad !== 0) $display("FAIL hold_init: %0d bad cycles, want 0", bad);
    else checks_passed++;
    checks_total++;
    if (upd_cnt !== 0 || dbg_target !== 4'd7)
      $display("FAIL hold_init_upd: pulses=%0d tgt=%0d, want 0/7", upd_cnt, dbg_target);
    else checks_passed++;
  endtask

  task automatic test_bounce();
    upd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sw = (i % 2 == 0) ? 4'd10 : 4'd7;
      tick(2);
    end
    sw = 4'd7;
    checks_total++;
    if (dbg_target !== 4'd7 || upd_cnt !== 0)
      $display("FAIL bounce_during: tgt=%0d pulses=%0d, want 7/0", dbg_target, upd_cnt);
    else checks_passed++;
    tick(20);
    checks_total++;
    if (dbg_target !== 4'd7 || duty !== 4'd7 || upd_cnt !== 0 || busy !== 1'b0)
      $display("FAIL bounce_settle: tgt=%0d duty=%0d pulses=%0d busy=%0b, want 7/7/0/0",
               dbg_target, duty, upd_cnt, busy);
    else checks_passed++;
  endtask

  task automatic test_ramp_up();
    upd_cnt = 0;
    sw = 4'd10;
    tick(6);
    checks_total++;
    if (dbg_target !== 4'd7) $display("FAIL deb_early: tgt=%0d, want 7", dbg_target);
    else checks_passed++;
    tick(1);
    checks_total++;
    if (dbg_target !== 4'd10 || busy !== 1'b1 || duty !== 4'd7)
      $display("FAIL deb_accept: tgt=%0d busy=%0b duty=%0d, want 10/1/7", dbg_target, busy, duty);
    else checks_passed++;
    tick(4);
    checks_total++;
    if (duty !== 4'd7) $display("FAIL step1_early: duty=%0d, want 7", duty);
    else checks_passed++;
    tick(1);
    checks_total++;
    if (duty !== 4'd8 || duty_upd !== 1'b1 || busy !== 1'b1)
      $display("FAIL step1: duty=%0d upd=%0b busy=%0b, want 8/1/1", duty, duty_upd, busy);
    else checks_passed++;
    tick(1);
    checks_total++;
    if (duty_upd !== 1'b0) $display("FAIL upd_width: upd=%0b, want 0", duty_upd);
    else checks_passed++;
    tick(3);
    checks_total++;
    if (duty !== 4'd9 || duty_upd !== 1'b1)
      $display("FAIL step2: duty=%0d upd=%0b, want 9/1", duty, duty_upd);
    else checks_passed++;
    tick(4);
    checks_total++;
    if (duty !== 4'd10 || busy !== 1'b0)
      $display("FAIL step3: duty=%0d busy=%0b, want 10/0", duty, busy);
    else checks_passed++;
    tick(10);
    checks_total++;
    if (duty !== 4'd10 || upd_cnt !== 3 || dbg_state !== 2'd0)
      $display("FAIL ramp_up_done: duty=%0d pulses=%0d st=%0d, want 10/3/0", duty, upd_cnt, dbg_state);
    else checks_passed++;
  endtask

  task automatic test_clamp();
    do_reset();
    sw = 4'd15;
    tick(40);
    checks_total++;
    if (duty !== 4'd12 || dbg_target !== 4'd12 || upd_cnt !== 5 || busy !== 1'b0)
      $display("FAIL clamp_high: duty=%0d tgt=%0d pulses=%0d busy=%0b, want 12/12/5/0",
               duty, dbg_target, upd_cnt, busy);
    else checks_passed++;
    upd_cnt = 0;
    sw = 4'd0;
    tick(60);
    checks_total++;
    if (duty !== 4'd2 || dbg_target !== 4'd2 || upd_cnt !== 10 || busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL clamp_low: duty=%0d tgt=%0d pulses=%0d busy=%0b st=%0d, want 2/2/10/0/0",
               duty, dbg_target, upd_cnt, busy, dbg_state);
    else checks_passed++;
  endtask

  task automatic test_retarget();
    bit ok;
    do_reset();
    sw = 4'd12;
    wait_duty(4'd8, 40, ok);
    checks_total++;
    if (!ok) $display("FAIL retarget_reach8: duty=%0d, want 8 within 40 cycles", duty);
    else checks_passed++;
    // new value lands in target while duty sits at 9
    sw = 4'd9;
    tick(7);
    checks_total++;
    if (duty !== 4'd9 || dbg_target !== 4'd9 || busy !== 1'b0)
      $display("FAIL retarget_land: duty=%0d tgt=%0d busy=%0b, want 9/9/0", duty, dbg_target, busy);
    else checks_passed++;
    tick(10);
    checks_total++;
    if (duty !== 4'd9 || upd_cnt !== 2 || dbg_state !== 2'd0 || busy !== 1'b0)
      $display("FAIL retarget_hold: duty=%0d pulses=%0d st=%0d busy=%0b, want 9/2/0/0",
               duty, upd_cnt, dbg_state, busy);
    else checks_passed++;
  endtask

  task automatic test_mid_ramp_reset();
    bit ok;
    do_reset();
    sw = 4'd12;
    wait_duty(4'd10, 60, ok);
    checks_total++;
    if (!ok) $display("FAIL mrst_reach10: duty=%0d, want 10 within 60 cycles", duty);
    else checks_passed++;
    rst = 1'b1;
    sw  = 4'd7;
    tick(1);
    checks_total++;
    if (duty !== 4'd7 || dbg_target !== 4'd7 || duty_upd !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL mid_ramp_reset: duty=%0d tgt=%0d upd=%0b busy=%0b st=%0d, want 7/7/0/0/0",
               duty, dbg_target, duty_upd, busy, dbg_state);
    else checks_passed++;
    rst = 1'b0;
    upd_cnt = 0;
    tick(20);
    checks_total++;
    if (duty !== 4'd7 || busy !== 1'b0 || upd_cnt !== 0)
      $display("FAIL post_reset_idle: duty=%0d busy=%0b pulses=%0d, want 7/0/0", duty, busy, upd_cnt);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_ramp_up();
    test_clamp();
    test_retarget();
    test_mid_ramp_reset();
    checks_total++;
    if (range_bad !== 0) $display("FAIL duty_range: %0d out-of-range cycles, want 0", range_bad);
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
